// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared mesh-router definitions: flit field offsets, route
//               label encodings and coordinate width.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    // Coordinate width of the mesh (X and Y each)
    localparam int COORD_W = 2;

    // Flit field offsets for the 40-bit flit
    localparam int SRC_HI  = 39;
    localparam int SRC_LO  = 36;
    localparam int DST_HI  = 35;
    localparam int DST_LO  = 32;
    localparam int TS_HI   = 31;
    localparam int TS_LO   = 24;
    localparam int DATA_HI = 23;
    localparam int DATA_LO = 2;
    localparam int TYPE_HI = 1;
    localparam int TYPE_LO = 0;

    // One-hot {W,N,E,S} route labels
    localparam logic [3:0] LBL_W     = 4'b1000;
    localparam logic [3:0] LBL_N     = 4'b0100;
    localparam logic [3:0] LBL_E     = 4'b0010;
    localparam logic [3:0] LBL_S     = 4'b0001;
    localparam logic [3:0] LBL_LOCAL = 4'b0000;
    localparam logic [3:0] LBL_NONE  = 4'b1111;

endpackage : noc_pkg
`default_nettype wire

// File: rtl/xy_route.sv
`default_nettype none
// ============================================================================
// Module      : xy_route
// Description : Combinational dimension-order (X first, then Y) route
//               computation for a head flit. Reports LBL_NONE when there is
//               no flit to route.
// Revision    : 1.0 - initial release
// ============================================================================
module xy_route
    import noc_pkg::*;
#(
    parameter int LOCAL_X = 0,
    parameter int LOCAL_Y = 0
) (
    input  logic [3:0] dst,
    input  logic       empty,
    output logic [3:0] label
);

    localparam logic [COORD_W-1:0] c_local_x = COORD_W'(LOCAL_X);
    localparam logic [COORD_W-1:0] c_local_y = COORD_W'(LOCAL_Y);

    logic [COORD_W-1:0] w_dst_x;
    logic [COORD_W-1:0] w_dst_y;

    assign w_dst_x = dst[3:2];
    assign w_dst_y = dst[1:0];

    // Resolve X first; only once X matches does Y decide the direction
    always_comb begin
        label = LBL_LOCAL;
        if (empty) begin
            label = LBL_NONE;
        end else if (w_dst_x < c_local_x) begin
            label = LBL_W;
        end else if (w_dst_x > c_local_x) begin
            label = LBL_E;
        end else if (w_dst_y < c_local_y) begin
            label = LBL_N;
        end else if (w_dst_y > c_local_y) begin
            label = LBL_S;
        end
    end

endmodule : xy_route
`default_nettype wire

// File: rtl/input_port_unit.sv
`default_nettype none
// ============================================================================
// Module      : input_port_unit
// Description : Router input stage. Buffers incoming flits in a DEPTH-entry
//               FIFO and presents the head flit with its XY route label to
//               the switch allocator, popping on the allocator's ready.
//               Optional macro IPU_STATS_EN adds pop / peak-occupancy
//               statistics outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module input_port_unit
    import noc_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 3,
    parameter int DATASIZE = 40,
    parameter int LOCAL_X  = 0,
    parameter int LOCAL_Y  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [DATASIZE-1:0] in_data,
    output logic                full,
    input  logic                ready,
    output logic [3:0]          label,
    output logic [DATASIZE-1:0] data_out,
    output logic                empty,
`ifdef IPU_STATS_EN
    output logic [15:0]         pop_count,
    output logic [WIDTH:0]      peak_count,
`endif
    output logic [WIDTH:0]      count
);

    localparam logic [WIDTH:0] c_full_count = (WIDTH+1)'(DEPTH);

    logic [DATASIZE-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0]    wptr_q, wptr_d;
    logic [WIDTH-1:0]    rptr_q, rptr_d;
    logic [WIDTH:0]      count_q, count_d;
    logic                w_push;
    logic                w_pop;

    // Status is decoded from the registered count so reset takes effect at once
    assign full     = (count_q == c_full_count);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign data_out = mem_q[rptr_q];

    // A full FIFO refuses the push even when the head is leaving this cycle
    assign w_push = in_valid && !full;
    assign w_pop  = ready && !empty;

    // Next-state for pointers and occupancy; pointers wrap by overflow
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (w_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (w_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Flit storage; contents are meaningless until written so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wptr_q] <= in_data;
        end
    end

    // Route label for the current head flit
    xy_route #(
        .LOCAL_X (LOCAL_X),
        .LOCAL_Y (LOCAL_Y)
    ) u_xy_route (
        .dst   (data_out[DST_HI:DST_LO]),
        .empty (empty),
        .label (label)
    );

`ifdef IPU_STATS_EN
    logic [15:0]    pop_count_q, pop_count_d;
    logic [WIDTH:0] peak_count_q, peak_count_d;

    // Saturating pop counter and running maximum of occupancy
    always_comb begin
        pop_count_d  = pop_count_q;
        peak_count_d = peak_count_q;
        if (w_pop && (pop_count_q != 16'hFFFF)) begin
            pop_count_d = pop_count_q + 16'd1;
        end
        if (count_q > peak_count_q) begin
            peak_count_d = count_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_count_q  <= '0;
            peak_count_q <= '0;
        end else begin
            pop_count_q  <= pop_count_d;
            peak_count_q <= peak_count_d;
        end
    end

    assign pop_count  = pop_count_q;
    assign peak_count = peak_count_q;
`endif

endmodule : input_port_unit
`default_nettype wire

// File: tb/tb_input_port_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_port_unit
// Description : Self-checking bench for input_port_unit at router (1,1):
//               route table, streaming, full/drop, full push+pop, pointer
//               wrap ordering and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_port_unit;

    localparam int DEPTH    = 8;
    localparam int WIDTH    = 3;
    localparam int DATASIZE = 40;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic [DATASIZE-1:0] in_data;
    logic                full;
    logic                ready;
    logic [3:0]          label;
    logic [DATASIZE-1:0] data_out;
    logic                empty;
    logic [WIDTH:0]      count;
`ifdef IPU_STATS_EN
    logic [15:0]         pop_count;
    logic [WIDTH:0]      peak_count;
`endif

    input_port_unit #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .DATASIZE (DATASIZE),
        .LOCAL_X  (1),
        .LOCAL_Y  (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .full     (full),
        .ready    (ready),
        .label    (label),
        .data_out (data_out),
        .empty    (empty),
`ifdef IPU_STATS_EN
        .pop_count  (pop_count),
        .peak_count (peak_count),
`endif
        .count    (count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] dst;
        logic [3:0] exp_label;
    } route_vec_t;

    route_vec_t          vecs [8];
    logic [DATASIZE-1:0] exp_q [$];
    logic [DATASIZE-1:0] f;
    logic [DATASIZE-1:0] dropped;
    int                  seq;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATASIZE-1:0] mk_flit(input int i, input logic [3:0] dst);
        return {4'hA, dst, 8'(i), 22'(i * 37 + 5), 2'(i)};
    endfunction

    initial begin
        // Route table for a router at (1,1): {dst_x, dst_y}
        vecs[0] = '{4'b0001, 4'b1000};  // x0 y1 -> W
        vecs[1] = '{4'b1001, 4'b0010};  // x2 y1 -> E
        vecs[2] = '{4'b0110, 4'b0001};  // x1 y2 -> S
        vecs[3] = '{4'b0100, 4'b0100};  // x1 y0 -> N
        vecs[4] = '{4'b0101, 4'b0000};  // x1 y1 -> local
        vecs[5] = '{4'b1101, 4'b0010};  // x3 y1 -> E
        vecs[6] = '{4'b0011, 4'b1000};  // x0 y3 -> W (X wins over Y)
        vecs[7] = '{4'b0111, 4'b0001};  // x1 y3 -> S

        rst_n    = 1'b0;
        in_valid = 1'b0;
        ready    = 1'b0;
        in_data  = '0;
        seq      = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_label", 64'(label), 64'hF);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full",  64'(full),  64'd0);
        chk("rst_count", 64'(count), 64'd0);
        rst_n = 1'b1;
        step();
        step();
        chk("idle_label", 64'(label), 64'hF);
        chk("idle_count", 64'(count), 64'd0);

        // Single flit into an empty FIFO: head and label visible next cycle
        for (int i = 0; i < 8; i++) begin
            f        = mk_flit(i, vecs[i].dst);
            in_valid = 1'b1;
            in_data  = f;
            step();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_label", i), 64'(label), 64'(vecs[i].exp_label));
            chk($sformatf("tbl%0d_data", i),  64'(data_out), 64'(f));
            chk($sformatf("tbl%0d_count", i), 64'(count), 64'd1);
            ready = 1'b1;
            step();
            ready = 1'b0;
            chk($sformatf("tbl%0d_empty", i), 64'(empty), 64'd1);
        end

        // Streaming with ready held: each flit is head for exactly one cycle
        ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = mk_flit(100 + i, vecs[i].dst);
            step();
            chk($sformatf("stream%0d_label", i), 64'(label), 64'(vecs[i].exp_label));
            chk($sformatf("stream%0d_data", i),  64'(data_out), 64'(mk_flit(100 + i, vecs[i].dst)));
            chk($sformatf("stream%0d_count", i), 64'(count), 64'd1);
        end
        in_valid = 1'b0;
        step();
        ready = 1'b0;
        chk("stream_drained", 64'(empty), 64'd1);

        // Nine pushes without popping: the ninth is dropped
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = mk_flit(200 + i, 4'(i));
            step();
            if (i == 6) chk("fill7_full", 64'(full), 64'd0);
            if (i == 7) chk("fill8_full", 64'(full), 64'd1);
        end
        in_valid = 1'b0;
        chk("drop_count", 64'(count), 64'd8);
        chk("drop_full",  64'(full),  64'd1);
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d_data", i), 64'(data_out), 64'(mk_flit(200 + i, 4'(i))));
            step();
            if (i == 0) chk("first_pop_full", 64'(full), 64'd0);
        end
        ready = 1'b0;
        chk("drain_empty", 64'(empty), 64'd1);

        // Full FIFO with push and pop together: only the pop happens
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = mk_flit(300 + i, 4'(i));
            step();
        end
        dropped = mk_flit(399, 4'hF);
        in_data = dropped;
        ready   = 1'b1;
        step();
        in_valid = 1'b0;
        chk("fullpp_count", 64'(count), 64'd7);
        chk("fullpp_full",  64'(full),  64'd0);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("fullpp_drain%0d", i), 64'(data_out), 64'(mk_flit(300 + i, 4'(i))));
            step();
        end
        ready = 1'b0;
        chk("fullpp_empty", 64'(empty), 64'd1);

        // Count held at 3 while streaming across several pointer wraps
        exp_q.delete();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            f       = mk_flit(400 + seq, 4'(seq));
            in_data = f;
            exp_q.push_back(f);
            seq++;
            step();
        end
        chk("wrap_pre_count", 64'(count), 64'd3);
        ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            f       = mk_flit(400 + seq, 4'(seq));
            in_data = f;
            seq++;
            chk($sformatf("wrap%0d_head", i), 64'(data_out), 64'(exp_q[0]));
            step();
            void'(exp_q.pop_front());
            exp_q.push_back(f);
            chk($sformatf("wrap%0d_count", i), 64'(count), 64'd3);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wrap_tail%0d", i), 64'(data_out), 64'(exp_q[0]));
            void'(exp_q.pop_front());
            step();
        end
        ready = 1'b0;
        chk("wrap_empty", 64'(empty), 64'd1);

        // Asynchronous reset between edges with five flits queued
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = mk_flit(500 + i, 4'b0101);
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_count", 64'(count), 64'd5);
        chk("pre_rst_label", 64'(label), 64'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_label", 64'(label), 64'hF);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
`ifdef IPU_STATS_EN
        chk("arst_pop_count",  64'(pop_count),  64'd0);
        chk("arst_peak_count", 64'(peak_count), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_label", 64'(label), 64'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_input_port_unit
`default_nettype wire
